ad9648_capture: RTL and testbench
=================================

AD9648_CAPTURE -- requirements
Module: ad9648_capture

Interface
REQ-001 Parameter: bit_width, 14, sample width per channel.
REQ-002 Parameter: depth, 1024, samples per capture; power of two, minimum 4.
REQ-003 Clocking and reset: one clock, clk_a; reset is synchronous and active-high.
REQ-004 clk_a  in  1  sample clock; all logic on posedge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 data_a_in  in  bit_width  channel A sample from the ADC interface stage; one new sample every cycle, no valid qualifier.
REQ-007 data_b_in  in  bit_width  channel B sample from the same stage, aligned with data_a_in.
REQ-008 overrange_a, overrange_b  in  1 each  ADC overrange flags, aligned with the samples.
REQ-009 arm  in  1  level/pulse; starts a capture from IDLE.
REQ-010 force_trig  in  1  immediate trigger while ARMED.
REQ-011 abort  in  1  cancels any activity.
REQ-012 threshold  in  bit_width  unsigned (offset-binary) trigger level on channel A.
REQ-013 out_data  out  2*bit_width  {A sample, B sample}; A in the upper half.
REQ-014 out_valid  out  1  out_data is valid.
REQ-015 out_ready  in  1  consumer accepts out_data.
REQ-016 busy  out  1  high in ARMED, CAPTURE and READOUT.
REQ-017 done  out  1  one-cycle pulse after the last readout transfer.
REQ-018 ovr_flag  out  1  sticky overrange indicator for the current capture.

Function
REQ-019 The FSM shall have four states: IDLE, ARMED, CAPTURE and READOUT.
REQ-020 IDLE transitions to ARMED on the next edge when arm=1 and abort=0; ovr_flag and all addresses clear on that edge.
REQ-021 ARMED holds the previous channel-A sample (prev_a) plus a prev_valid bit; prev_valid clears on entry to ARMED and sets after the first sampled cycle.
REQ-022 Trigger in ARMED fires when (prev_valid and prev_a < threshold and data_a_in >= threshold), unsigned compare, or when force_trig=1.
REQ-023 On the trigger cycle, the current {A,B} sample is written to address 0 and the FSM enters CAPTURE.
REQ-024 CAPTURE writes one sample per cycle to consecutive addresses; after address depth-1 is written (depth samples in total, trigger sample included), the FSM enters READOUT.
REQ-025 ovr_flag sets if overrange_a or overrange_b is high on any written sample; samples seen in ARMED before the trigger do not set it.
REQ-026 READOUT presents addresses 0..depth-1 in order; the first out_valid rises no later than 2 cycles after READOUT entry.
REQ-027 A transfer occurs when out_valid and out_ready are both high; out_data is held stable while out_valid=1 and out_ready=0.
REQ-028 READOUT sustains one transfer per cycle when out_ready is held high; no word is dropped or duplicated.
REQ-029 After the transfer of address depth-1: out_valid falls, done pulses for one cycle, and the FSM returns to IDLE.
REQ-030 arm is ignored outside IDLE, and force_trig is ignored outside ARMED.
REQ-031 abort=1 returns the FSM to IDLE on the next edge from any state; out_valid falls, done does not pulse, and ovr_flag is held.
REQ-032 abort wins over a simultaneous arm, trigger or transfer.
REQ-033 The sample buffer is depth x 2*bit_width and is inferable as single-clock block RAM with one-cycle read latency.

Reset
REQ-034 While reset=1, the FSM is in IDLE and out_valid=0, done=0, busy=0, ovr_flag=0, with all addresses and prev_valid cleared.
REQ-035 Reset mid-capture or mid-readout discards the capture; buffer contents need not be cleared.
REQ-036 Reset has priority over all other inputs.

Verification (depth=8, bit_width=14)
REQ-037 Ramp A = 90,91,... each cycle, B = A+1000, threshold=100, then arm -> 8 words {100,1100}..{107,1107}, followed by one done pulse and busy=0.
REQ-038 A constant 0, arm then force_trig on the second ARMED cycle -> 8 words with A=0 and the B values from the trigger cycle onward.
REQ-039 During readout, toggle out_ready 1,0,0,1,... -> exactly 8 transfers in order, with out_data unchanged across stall cycles.
REQ-040 Pulse overrange_b once during CAPTURE -> ovr_flag=1 until the next arm accept; a pulse in ARMED before the trigger -> ovr_flag stays 0.
REQ-041 Arm while A=200 and threshold=100 -> no trigger until A drops below 100 and recrosses it; abort asserted mid-CAPTURE -> IDLE next cycle, no out_valid, and a re-arm captures normally.

Source files
------------

// File: rtl/ad9648_capture_if.sv
// Readout stream from the AD9648 capture buffer: {A,B} words with valid/ready handshake.
interface ad9648_capture_if #(
   parameter int unsigned bit_width = 14
);
   logic [2*bit_width-1:0] out_data;
   logic                   out_valid;
   logic                   out_ready;

   modport master (
      output out_data,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/ad9648_capture.sv
// Triggered two-channel ADC snapshot: arm, trigger on channel-A rising threshold crossing
// (or force), store depth samples in block RAM, then stream them out with backpressure.
module ad9648_capture #(
   parameter int unsigned bit_width = 14,
   parameter int unsigned depth     = 1024
) (
   input  logic                 clk_a,
   input  logic                 reset,
   input  logic [bit_width-1:0] data_a_in,
   input  logic [bit_width-1:0] data_b_in,
   input  logic                 overrange_a,
   input  logic                 overrange_b,
   input  logic                 arm,
   input  logic                 force_trig,
   input  logic                 abort,
   input  logic [bit_width-1:0] threshold,
   ad9648_capture_if.master     stream,
   output logic                 busy,
   output logic                 done,
   output logic                 ovr_flag
);

   localparam int unsigned aw    = $clog2(depth);
   localparam int unsigned cnt_w = aw + 1;
   localparam logic [aw-1:0]    last_addr = aw'(depth - 1);
   localparam logic [cnt_w-1:0] cnt_full  = cnt_w'(depth);

   typedef enum logic [1:0] {StIdle, StArmed, StCapture, StReadout} state_e;

   state_e                 state_q, state_d;
   logic [bit_width-1:0]   prev_a_q, prev_a_d;
   logic                   prev_valid_q, prev_valid_d;
   logic [aw-1:0]          wr_addr_q, wr_addr_d;
   logic [cnt_w-1:0]       rd_cnt_q, rd_cnt_d;
   logic                   out_valid_q, out_valid_d;
   logic                   done_q, done_d;
   logic                   ovr_q, ovr_d;
   logic                   wr_en, rd_en, trig, xfer, ovr_in;
   logic [2*bit_width-1:0] rd_data_q;
   logic [2*bit_width-1:0] mem [depth];

   always_comb begin
      state_d      = state_q;
      prev_a_d     = prev_a_q;
      prev_valid_d = prev_valid_q;
      wr_addr_d    = wr_addr_q;
      rd_cnt_d     = rd_cnt_q;
      out_valid_d  = out_valid_q;
      done_d       = 1'b0;
      ovr_d        = ovr_q;
      wr_en        = 1'b0;
      rd_en        = 1'b0;
      ovr_in       = overrange_a | overrange_b;
      xfer         = out_valid_q & stream.out_ready;
      trig         = (prev_valid_q && (prev_a_q < threshold) && (data_a_in >= threshold)) ||
                     force_trig;

      if (abort) begin
         state_d     = StIdle;
         out_valid_d = 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (arm) begin
                  state_d      = StArmed;
                  ovr_d        = 1'b0;
                  wr_addr_d    = '0;
                  rd_cnt_d     = '0;
                  prev_valid_d = 1'b0;
               end
            end
            StArmed: begin
               prev_a_d     = data_a_in;
               prev_valid_d = 1'b1;
               if (trig) begin
                  // wr_addr_q is zero here, so the trigger sample lands at address 0
                  wr_en     = 1'b1;
                  wr_addr_d = wr_addr_q + aw'(1);
                  state_d   = StCapture;
                  if (ovr_in) ovr_d = 1'b1;
               end
            end
            StCapture: begin
               wr_en     = 1'b1;
               wr_addr_d = wr_addr_q + aw'(1);
               if (ovr_in) ovr_d = 1'b1;
               if (wr_addr_q == last_addr) begin
                  state_d  = StReadout;
                  rd_cnt_d = '0;
               end
            end
            StReadout: begin
               // The RAM output register is the output stage; a read is issued only when
               // that register is empty or being consumed, so stalled data stays put.
               if ((rd_cnt_q != cnt_full) && (!out_valid_q || stream.out_ready)) begin
                  rd_en       = 1'b1;
                  rd_cnt_d    = rd_cnt_q + cnt_w'(1);
                  out_valid_d = 1'b1;
               end else if (xfer) begin
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
                  state_d     = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_a) begin
      if (reset) begin
         state_q      <= StIdle;
         prev_a_q     <= '0;
         prev_valid_q <= 1'b0;
         wr_addr_q    <= '0;
         rd_cnt_q     <= '0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         ovr_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         prev_a_q     <= prev_a_d;
         prev_valid_q <= prev_valid_d;
         wr_addr_q    <= wr_addr_d;
         rd_cnt_q     <= rd_cnt_d;
         out_valid_q  <= out_valid_d;
         done_q       <= done_d;
         ovr_q        <= ovr_d;
      end
   end

   // Sample buffer: no reset so it maps onto block RAM with a registered read port.
   always_ff @(posedge clk_a) begin
      if (wr_en) mem[wr_addr_q] <= {data_a_in, data_b_in};
      if (rd_en) rd_data_q <= mem[rd_cnt_q[aw-1:0]];
   end

   assign stream.out_data  = rd_data_q;
   assign stream.out_valid = out_valid_q;
   assign busy             = (state_q != StIdle);
   assign done             = done_q;
   assign ovr_flag         = ovr_q;

endmodule

// File: tb/tb_ad9648_capture.sv
// Directed bench for ad9648_capture (depth 8, 14-bit) with an expected-word scoreboard.
module tb_ad9648_capture;

   localparam int unsigned bit_width = 14;
   localparam int unsigned depth     = 8;

   logic                 clk_a = 1'b0;
   logic                 reset = 1'b1;
   logic [bit_width-1:0] data_a = '0, data_b = '0, threshold = '0;
   logic                 ovr_a = 1'b0, ovr_b = 1'b0, arm = 1'b0, force_trig = 1'b0;
   logic                 abort = 1'b0;
   logic                 busy, done, ovr_flag;

   bit inc_a = 1'b0, inc_b = 1'b0;
   int ready_mode = 0, pat = 0;
   int n_cmp = 0, n_fail = 0, n_done = 0;
   logic [2*bit_width-1:0] sb_q[$];
   logic                   last_valid = 1'b0, last_ready = 1'b0, last_kill = 1'b0;
   logic [2*bit_width-1:0] last_data = '0;

   always #5 clk_a = ~clk_a;

   ad9648_capture_if #(.bit_width(bit_width)) stream ();

   ad9648_capture #(
      .bit_width(bit_width),
      .depth    (depth)
   ) u_dut (
      .clk_a      (clk_a),
      .reset      (reset),
      .data_a_in  (data_a),
      .data_b_in  (data_b),
      .overrange_a(ovr_a),
      .overrange_b(ovr_b),
      .arm        (arm),
      .force_trig (force_trig),
      .abort      (abort),
      .threshold  (threshold),
      .stream     (stream),
      .busy       (busy),
      .done       (done),
      .ovr_flag   (ovr_flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Observe what the coming posedge will do, let it happen, then apply free-running drives.
   task automatic tick();
      logic [2*bit_width-1:0] e;
      logic                   kill;
      kill = reset | abort;
      if (last_valid && !last_ready && !last_kill) begin
         check("stall_valid", 32'(stream.out_valid), 32'd1);
         check("stall_data", 32'(stream.out_data), 32'(last_data));
      end
      if (stream.out_valid === 1'b1 && stream.out_ready && !kill) begin
         n_cmp++;
         assert (sb_q.size() > 0) else begin
            n_fail++;
            $error("FAIL xfer_extra: observed word %0h expected no transfer", stream.out_data);
         end
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("xfer_data", 32'(stream.out_data), 32'(e));
         end
      end
      if (done === 1'b1) n_done++;
      last_valid = stream.out_valid;
      last_ready = stream.out_ready;
      last_kill  = kill;
      last_data  = stream.out_data;
      @(negedge clk_a);
      if (inc_a) data_a++;
      if (inc_b) data_b++;
      pat++;
      stream.out_ready = (ready_mode == 0) || (pat % 3 == 0);
   endtask

   task automatic push_words(input logic [bit_width-1:0] a0, input logic [bit_width-1:0] b0,
                             input bit step_a, input bit step_b);
      for (int i = 0; i < int'(depth); i++)
         sb_q.push_back({a0 + (step_a ? bit_width'(i) : '0), b0 + (step_b ? bit_width'(i) : '0)});
   endtask

   task automatic wait_done(input string tag);
      int d0;
      int i;
      d0 = n_done;
      i  = 0;
      while (n_done == d0 && i < 200) begin
         tick();
         i++;
      end
      check({tag, "_done"}, 32'(n_done - d0), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
      tick();
      tick();
      check({tag, "_done_once"}, 32'(n_done - d0), 32'd1);
   endtask

   task automatic arm_once();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      stream.out_ready = 1'b1;
      repeat (3) tick();
      check("rst_valid", 32'(stream.out_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_ovr", 32'(ovr_flag), 32'd0);
      reset = 1'b0;
      tick();

      // Rising crossing of threshold on a ramp
      threshold = 14'd100;
      data_a = 14'd90;
      data_b = 14'd1090;
      inc_a = 1'b1;
      inc_b = 1'b1;
      push_words(14'd100, 14'd1100, 1'b1, 1'b1);
      arm_once();
      check("t1_busy_armed", 32'(busy), 32'd1);
      wait_done("t1");

      // Forced trigger on the second armed cycle
      inc_a = 1'b0;
      data_a = '0;
      data_b = 14'd500;
      arm_once();
      tick();
      force_trig = 1'b1;
      push_words(14'd0, data_b, 1'b0, 1'b1);
      tick();
      force_trig = 1'b0;
      wait_done("t2");

      // Backpressure pattern 1,0,0 during readout
      ready_mode = 1;
      pat = 0;
      inc_a = 1'b1;
      data_a = 14'd1000;
      data_b = 14'd3000;
      arm_once();
      force_trig = 1'b1;
      push_words(data_a, data_b, 1'b1, 1'b1);
      tick();
      force_trig = 1'b0;
      wait_done("t3");
      ready_mode = 0;

      // Overrange before the trigger must not count
      inc_a = 1'b0;
      inc_b = 1'b0;
      data_a = 14'd5;
      data_b = 14'd6;
      arm_once();
      ovr_b = 1'b1;
      tick();
      ovr_b = 1'b0;
      force_trig = 1'b1;
      push_words(data_a, data_b, 1'b0, 1'b0);
      tick();
      force_trig = 1'b0;
      wait_done("t4a");
      check("t4a_ovr_armed", 32'(ovr_flag), 32'd0);

      // Overrange during capture is sticky until the next arm
      arm_once();
      force_trig = 1'b1;
      push_words(data_a, data_b, 1'b0, 1'b0);
      tick();
      force_trig = 1'b0;
      tick();
      ovr_b = 1'b1;
      tick();
      ovr_b = 1'b0;
      wait_done("t4b");
      check("t4b_ovr_set", 32'(ovr_flag), 32'd1);
      repeat (3) tick();
      check("t4b_ovr_sticky", 32'(ovr_flag), 32'd1);

      // Armed above threshold: needs a drop below and a recross
      data_a = 14'd200;
      data_b = 14'd7;
      arm_once();
      check("t5_ovr_clear", 32'(ovr_flag), 32'd0);
      repeat (6) tick();
      check("t5_still_armed", 32'(busy), 32'd1);
      check("t5_no_valid", 32'(stream.out_valid), 32'd0);
      data_a = 14'd50;
      tick();
      tick();
      data_a = 14'd99;
      tick();
      data_a = 14'd100;
      push_words(14'd100, 14'd7, 1'b1, 1'b0);
      inc_a = 1'b1;
      tick();
      wait_done("t5");
      inc_a = 1'b0;

      // Abort mid-capture, abort beats arm, then a clean re-arm
      data_a = 14'd1;
      arm_once();
      force_trig = 1'b1;
      tick();
      force_trig = 1'b0;
      repeat (3) tick();
      begin
         int d0;
         d0 = n_done;
         abort = 1'b1;
         tick();
         abort = 1'b0;
         check("t6_abort_busy", 32'(busy), 32'd0);
         for (int i = 0; i < 12; i++) begin
            check("t6_abort_no_valid", 32'(stream.out_valid), 32'd0);
            tick();
         end
         check("t6_abort_no_done", 32'(n_done - d0), 32'd0);
      end
      arm = 1'b1;
      abort = 1'b1;
      tick();
      arm = 1'b0;
      abort = 1'b0;
      check("t6_abort_beats_arm", 32'(busy), 32'd0);
      data_b = 14'd9;
      arm_once();
      force_trig = 1'b1;
      push_words(data_a, data_b, 1'b0, 1'b0);
      tick();
      force_trig = 1'b0;
      wait_done("t6");

      // Reset in the middle of readout discards the capture
      ovr_a = 1'b1;
      arm_once();
      force_trig = 1'b1;
      push_words(data_a, data_b, 1'b0, 1'b0);
      tick();
      force_trig = 1'b0;
      ovr_a = 1'b0;
      for (int i = 0; i < 30 && stream.out_valid !== 1'b1; i++) tick();
      tick();
      reset = 1'b1;
      tick();
      check("t7_rst_valid", 32'(stream.out_valid), 32'd0);
      check("t7_rst_busy", 32'(busy), 32'd0);
      check("t7_rst_ovr", 32'(ovr_flag), 32'd0);
      reset = 1'b0;
      sb_q.delete();
      repeat (4) tick();
      check("t7_idle_valid", 32'(stream.out_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
